// File: rtl/psa_16bit_unit.sv
// rtl/psa_16bit_unit.sv - 16-bit add/sub with 4x4-bit saturating partitioned mode; build macro PSA_SAT16_EN saturates 16-bit results
module psa_16bit_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        Sub,
   input  logic        pad,
   output logic [15:0] Sum,
   output logic        Ovfl
);

   // Subtraction is A + ~B + 1: invert B here and inject Sub as carry-in.
   logic [15:0] b_eff;
   assign b_eff = Sub ? ~B : B;

   logic [3:0]  lane_cout;
   logic [3:0]  lane_ovf;
   logic [15:0] raw_sum;
   logic [15:0] sat_sum;

   // One 4-bit adder per lane. The carry-in is either the chained carry
   // from the lane below (16-bit mode) or Sub (partitioned mode). Each
   // lane is split at bit 3 so that carry-into-MSB xor carry-out gives
   // the signed overflow of that lane; for lane 3 in chained mode this
   // is exactly the 16-bit signed overflow.
   for (genvar g = 0; g < 4; g++) begin : g_lane
      logic [3:0] a_l;
      logic [3:0] b_l;
      logic       cin;
      logic [3:0] low;
      logic [1:0] high;

      assign a_l = A[4*g +: 4];
      assign b_l = b_eff[4*g +: 4];

      if (g == 0) begin : g_cin0
         assign cin = Sub;
      end else begin : g_cinn
         assign cin = pad ? Sub : lane_cout[g-1];
      end

      assign low  = {1'b0, a_l[2:0]} + {1'b0, b_l[2:0]} + {3'b000, cin};
      assign high = {1'b0, a_l[3]} + {1'b0, b_l[3]} + {1'b0, low[3]};

      assign lane_cout[g]       = high[1];
      assign lane_ovf[g]        = low[3] ^ high[1];
      assign raw_sum[4*g +: 4]  = {high[0], low[2:0]};
      // On overflow both effective operands share A's sign, so A's lane
      // MSB tells which rail to clamp to.
      assign sat_sum[4*g +: 4]  = lane_ovf[g] ? (a_l[3] ? 4'h8 : 4'h7)
                                              : {high[0], low[2:0]};
   end

   logic [15:0] sum_d;
   logic        ovfl_d;
   logic [15:0] sum_q;
   logic        ovfl_q;

   // Select the mode result and overflow flag that the register captures.
   always_comb begin
      sum_d  = raw_sum;
      ovfl_d = lane_ovf[3];
      if (pad) begin
         sum_d  = sat_sum;
         ovfl_d = |lane_ovf;
      end else begin
`ifdef PSA_SAT16_EN
         if (lane_ovf[3]) begin
            sum_d = A[15] ? 16'h8000 : 16'h7FFF;
         end
`endif
      end
   end

   // Output register; reset clears the result immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q  <= 16'h0000;
         ovfl_q <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         ovfl_q <= ovfl_d;
      end
   end

   assign Sum  = sum_q;
   assign Ovfl = ovfl_q;

endmodule

// File: tb/tb_psa_16bit_unit.sv
// tb/tb_psa_16bit_unit.sv - self-checking bench for psa_16bit_unit
module tb_psa_16bit_unit;

   logic        clk;
   logic        rst_n;
   logic [15:0] A;
   logic [15:0] B;
   logic        Sub;
   logic        pad;
   logic [15:0] Sum;
   logic        Ovfl;

   int checks;
   int failures;

   psa_16bit_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (A),
      .B     (B),
      .Sub   (Sub),
      .pad   (pad),
      .Sum   (Sum),
      .Ovfl  (Ovfl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Arithmetic reference: {Ovfl, Sum} from signed integer math and clamping.
   function automatic logic [16:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic sub, input logic pd);
      int         r;
      int         la;
      int         lb;
      logic [15:0] s;
      logic        o;
      logic [3:0]  nib;
      s = 16'h0000;
      o = 1'b0;
      if (!pd) begin
         r = sub ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
         o = (r > 32767) || (r < -32768);
         s = r[15:0];
`ifdef PSA_SAT16_EN
         if (r > 32767) s = 16'h7FFF;
         else if (r < -32768) s = 16'h8000;
`endif
      end else begin
         for (int i = 0; i < 4; i++) begin
            nib = a[4*i +: 4];
            la  = int'($signed(nib));
            nib = b[4*i +: 4];
            lb  = int'($signed(nib));
            r   = sub ? (la - lb) : (la + lb);
            if (r > 7) begin
               r = 7;
               o = 1'b1;
            end else if (r < -8) begin
               r = -8;
               o = 1'b1;
            end
            s[4*i +: 4] = r[3:0];
         end
      end
      return {o, s};
   endfunction

   task automatic drive_and_check(input string name, input logic [15:0] a, input logic [15:0] b,
                                  input logic sub, input logic pd);
      logic [16:0] exp;
      @(negedge clk);
      A = a; B = b; Sub = sub; pad = pd;
      exp = ref_model(a, b, sub, pd);
      @(posedge clk);
      #1;
      checks++;
      if ({Ovfl, Sum} !== exp) begin
         failures++;
         $display("FAIL %s A=%h B=%h Sub=%b pad=%b got Sum=%h Ovfl=%b expected Sum=%h Ovfl=%b",
                  name, a, b, sub, pd, Sum, Ovfl, exp[15:0], exp[16]);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      A = 16'h7FFF; B = 16'h0001; Sub = 1'b0; pad = 1'b0;
      #2;
      checks++;
      if (Sum !== 16'h0000 || Ovfl !== 1'b0) begin
         failures++;
         $display("FAIL reset_initial got Sum=%h Ovfl=%b expected Sum=0000 Ovfl=0", Sum, Ovfl);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (Sum !== 16'h0000 || Ovfl !== 1'b0) begin
         failures++;
         $display("FAIL reset_held got Sum=%h Ovfl=%b expected Sum=0000 Ovfl=0", Sum, Ovfl);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed;
      drive_and_check("add_small",    16'h0004, 16'h0002, 1'b0, 1'b0);
      drive_and_check("add_ovf16",    16'h7FFF, 16'h0001, 1'b0, 1'b0);
      drive_and_check("sub_neg",      16'h0003, 16'h0005, 1'b1, 1'b0);
      drive_and_check("sub_ovf16",    16'h8000, 16'h0001, 1'b1, 1'b0);
      drive_and_check("sub_minneg",   16'h0000, 16'h8000, 1'b1, 1'b0);
      drive_and_check("add_negovf16", 16'h8000, 16'hFFFF, 1'b0, 1'b0);
      drive_and_check("lane_sat_pos", 16'h7531, 16'h1234, 1'b0, 1'b1);
      drive_and_check("lane_sat_neg", 16'h8000, 16'hF000, 1'b0, 1'b1);
      drive_and_check("lane_sub_neg", 16'h8000, 16'h1000, 1'b1, 1'b1);
      drive_and_check("lane_nocarry", 16'h0F0F, 16'h0101, 1'b0, 1'b1);
      drive_and_check("lane_noborrow",16'h0000, 16'h0101, 1'b1, 1'b1);
   endtask

   task automatic test_random_16;
      logic [15:0] edges [6];
      logic [15:0] a;
      logic [15:0] b;
      edges = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001, 16'h8001};
      for (int i = 0; i < 200; i++) begin
         a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : 16'($urandom);
         b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : 16'($urandom);
         drive_and_check("rand16", a, b, 1'($urandom), 1'b0);
      end
   endtask

   task automatic test_random_pad;
      for (int i = 0; i < 200; i++) begin
         drive_and_check("randpad", 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
      end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 100; i++) begin
         drive_and_check("b2b", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      end
   endtask

   task automatic test_reset_midop;
      drive_and_check("midop_setup", 16'h7531, 16'h1234, 1'b0, 1'b1);
      checks++;
      if (Sum !== 16'h7765 || Ovfl !== 1'b1) begin
         failures++;
         $display("FAIL midop_hold got Sum=%h Ovfl=%b expected Sum=7765 Ovfl=1", Sum, Ovfl);
      end
      @(negedge clk);
      A = 16'h0004; B = 16'h0002; Sub = 1'b0; pad = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (Sum !== 16'h0000 || Ovfl !== 1'b0) begin
         failures++;
         $display("FAIL midop_async_clear got Sum=%h Ovfl=%b expected Sum=0000 Ovfl=0", Sum, Ovfl);
      end
      @(posedge clk);
      #1;
      checks++;
      if (Sum !== 16'h0000 || Ovfl !== 1'b0) begin
         failures++;
         $display("FAIL midop_discard got Sum=%h Ovfl=%b expected Sum=0000 Ovfl=0", Sum, Ovfl);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (Sum !== 16'h0000 || Ovfl !== 1'b0) begin
         failures++;
         $display("FAIL midop_release got Sum=%h Ovfl=%b expected Sum=0000 Ovfl=0", Sum, Ovfl);
      end
      @(posedge clk);
      #1;
      checks++;
      if (Sum !== 16'h0006 || Ovfl !== 1'b0) begin
         failures++;
         $display("FAIL midop_resume got Sum=%h Ovfl=%b expected Sum=0006 Ovfl=0", Sum, Ovfl);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_directed();
      test_random_16();
      test_random_pad();
      test_back_to_back();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete got running expected finished");
      $fatal(1);
   end

endmodule
